// File: rtl/ball_plat_drawer_pkg.sv
// Shared definitions for the ball/platform pixel drawer: screen geometry,
// colour constants, platform field layout, drawer state encoding and small
// pixel-math helpers.
package ball_plat_drawer_pkg;

    // Colours and screen geometry
    localparam logic [2:0] BLACK      = 3'b000;
    localparam logic [7:0] SCREEN_W   = 8'd160;
    localparam logic [8:0] SCREEN_H   = 9'd160;

    // Ball geometry
    localparam logic [7:0] BALL_X     = 8'd76;
    localparam logic [7:0] BALL_SIZE  = 8'd4;

    // Platform geometry and packed-field layout
    localparam logic [7:0] PLAT_X0    = 8'd40;
    localparam logic [7:0] PLAT_PITCH = 8'd20;
    localparam logic [7:0] PLAT_W     = 8'd8;
    localparam logic [7:0] NUM_PLATS  = 8'd4;
    localparam int         PLAT_POS_W = 7;
    localparam int         PLAT_COL_W = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ERASE = 3'd2,
        S_PLATS = 3'd3,
        S_BALL  = 3'd4,
        S_DONE  = 3'd5
    } drawer_state_e;

    // y position of platform idx from the packed position bus
    function automatic logic [6:0] plat_y(input logic [27:0] pos, input logic [1:0] idx);
        return pos[idx*PLAT_POS_W +: PLAT_POS_W];
    endfunction

    // colour of platform idx from the packed colour bus
    function automatic logic [2:0] plat_colour(input logic [11:0] cols, input logic [1:0] idx);
        return cols[idx*PLAT_COL_W +: PLAT_COL_W];
    endfunction

    // x of pixel k of platform idx
    function automatic logic [7:0] plat_x(input logic [7:0] idx, input logic [7:0] k);
        logic [7:0] offs;
        offs = idx * PLAT_PITCH;
        return PLAT_X0 + offs + k;
    endfunction

    // Row base+off is on screen; the 9-bit sum clips rows that wrap past 255
    function automatic logic row_visible(input logic [7:0] base, input logic [7:0] off);
        logic [8:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        return (sum < SCREEN_H);
    endfunction

endpackage

// File: rtl/ball_plat_drawer_if.sv
// Controller <-> drawer bundle: frame request, game-state snapshot inputs and
// the pixel-plot stream towards the VGA adapter.
interface ball_plat_drawer_if;
    logic        start;
    logic [7:0]  prev_ball;
    logic [7:0]  curr_ball;
    logic [27:0] position_plats;
    logic [11:0] color_plats;
    logic [2:0]  color_ball;
    logic        clear;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    modport master (
        output start, prev_ball, curr_ball, position_plats, color_plats, color_ball, clear,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, prev_ball, curr_ball, position_plats, color_plats, color_ball, clear,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/ball_plat_drawer_rect.sv
// rect_raster: walks (dx,dy) over a w-by-h rectangle, dx inner, dy outer.
// load_i restarts at (0,0) with new dimensions and wins over step_i.
// last_o flags the final coordinate of the rectangle.
module rect_raster (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       step_i,
    input  logic [7:0] w_i,
    input  logic [7:0] h_i,
    output logic [7:0] dx_o,
    output logic [7:0] dy_o,
    output logic       last_o
);
    logic [7:0] w_q, h_q;
    logic [7:0] dx_q, dx_d;
    logic [7:0] dy_q, dy_d;
    logic       dx_end_s, dy_end_s;

    assign dx_end_s = (dx_q == (w_q - 8'd1));
    assign dy_end_s = (dy_q == (h_q - 8'd1));

    // Next coordinate: reload, raster step, or hold
    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        if (load_i) begin
            dx_d = 8'd0;
            dy_d = 8'd0;
        end else if (step_i) begin
            if (dx_end_s) begin
                dx_d = 8'd0;
                if (dy_end_s) begin
                    dy_d = 8'd0;
                end else begin
                    dy_d = dy_q + 8'd1;
                end
            end else begin
                dx_d = dx_q + 8'd1;
                dy_d = dy_q;
            end
        end else begin
            dx_d = dx_q;
            dy_d = dy_q;
        end
    end

    // Coordinate and dimension registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dx_q <= 8'd0;
            dy_q <= 8'd0;
            w_q  <= 8'd0;
            h_q  <= 8'd0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
            if (load_i) begin
                w_q <= w_i;
                h_q <= h_i;
            end else begin
                w_q <= w_q;
                h_q <= h_q;
            end
        end
    end

    assign dx_o   = dx_q;
    assign dy_o   = dy_q;
    assign last_o = dx_end_s && dy_end_s;

endmodule

// File: rtl/ball_plat_drawer.sv
// ball_plat_drawer: once per frame, snapshots the game state on start and
// streams plot commands: erase old ball, draw 4 platforms, draw new ball,
// then a one-cycle done. One pixel per cycle with registered outputs; rows
// at or beyond the screen bottom keep their cycle but do not plot.
// Optional: DRAWER_CLEAR_EN adds a full-screen black clear ahead of the
// frame when clear is high at the latching start.
module ball_plat_drawer
    import ball_plat_drawer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    ball_plat_drawer_if.slave bus
);
    drawer_state_e state_q, state_d;

    // Frame snapshot
    logic [7:0]  prev_q, curr_q;
    logic [27:0] pos_q;
    logic [11:0] cols_q;
    logic [2:0]  ball_col_q;
    logic        snap_en_s;

    // Registered pixel outputs
    logic [7:0] x_q, x_d, y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d, busy_q, busy_d, done_q, done_d;

    // Raster control
    logic       rr_load_s, rr_step_s, rr_last_s;
    logic [7:0] rr_w_s, rr_h_s, dx_s, dy_s;

    rect_raster u_raster (
        .clk    (clk),
        .reset  (reset),
        .load_i (rr_load_s),
        .step_i (rr_step_s),
        .w_i    (rr_w_s),
        .h_i    (rr_h_s),
        .dx_o   (dx_s),
        .dy_o   (dy_s),
        .last_o (rr_last_s)
    );

    // Phase sequencing and pixel generation for the current raster point
    always_comb begin
        state_d   = state_q;
        snap_en_s = 1'b0;
        rr_load_s = 1'b0;
        rr_step_s = 1'b0;
        rr_w_s    = BALL_SIZE;
        rr_h_s    = BALL_SIZE;
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        plot_d    = 1'b0;
        done_d    = 1'b0;
        busy_d    = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    snap_en_s = 1'b1;
                    rr_load_s = 1'b1;
`ifdef DRAWER_CLEAR_EN
                    if (bus.clear) begin
                        rr_w_s  = SCREEN_W;
                        rr_h_s  = SCREEN_H[7:0];
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_ERASE;
                    end
`else
                    state_d = S_ERASE;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef DRAWER_CLEAR_EN
            S_CLEAR: begin
                x_d       = dx_s;
                y_d       = dy_s;
                colour_d  = BLACK;
                plot_d    = 1'b1;
                rr_step_s = 1'b1;
                if (rr_last_s) begin
                    rr_load_s = 1'b1;
                    state_d   = S_ERASE;
                end else begin
                    state_d   = S_CLEAR;
                end
            end
`endif
            S_ERASE: begin
                x_d       = BALL_X + dx_s;
                y_d       = prev_q + dy_s;
                colour_d  = BLACK;
                plot_d    = row_visible(prev_q, dy_s);
                rr_step_s = 1'b1;
                if (rr_last_s) begin
                    rr_load_s = 1'b1;
                    rr_w_s    = PLAT_W;
                    rr_h_s    = NUM_PLATS;
                    state_d   = S_PLATS;
                end else begin
                    state_d   = S_ERASE;
                end
            end
            S_PLATS: begin
                // dy selects the platform, dx walks along it
                x_d       = plat_x(dy_s, dx_s);
                y_d       = {1'b0, plat_y(pos_q, dy_s[1:0])};
                colour_d  = plat_colour(cols_q, dy_s[1:0]);
                plot_d    = 1'b1;
                rr_step_s = 1'b1;
                if (rr_last_s) begin
                    rr_load_s = 1'b1;
                    state_d   = S_BALL;
                end else begin
                    state_d   = S_PLATS;
                end
            end
            S_BALL: begin
                x_d       = BALL_X + dx_s;
                y_d       = curr_q + dy_s;
                colour_d  = ball_col_q;
                plot_d    = row_visible(curr_q, dy_s);
                rr_step_s = 1'b1;
                if (rr_last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_BALL;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Game-state snapshot taken only on the accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q     <= 8'd0;
            curr_q     <= 8'd0;
            pos_q      <= 28'd0;
            cols_q     <= 12'd0;
            ball_col_q <= 3'd0;
        end else if (snap_en_s) begin
            prev_q     <= bus.prev_ball;
            curr_q     <= bus.curr_ball;
            pos_q      <= bus.position_plats;
            cols_q     <= bus.color_plats;
            ball_col_q <= bus.color_ball;
        end else begin
            prev_q     <= prev_q;
            curr_q     <= curr_q;
            pos_q      <= pos_q;
            cols_q     <= cols_q;
            ball_col_q <= ball_col_q;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q      <= 8'd0;
            y_q      <= 8'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_ball_plat_drawer.sv
// Scoreboard bench for ball_plat_drawer: stimulus pushes expected plotted
// pixels (with their cycle) and expected done cycles into queues; a monitor
// process pops and compares on every plot and every done.
module tb_ball_plat_drawer;

    typedef struct {
        int         cyc;
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pix_t;

    logic clk;
    logic reset;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    pix_t exp_q[$];
    int   done_q[$];

    // Frame configuration used by both the driver and the model
    int f_prev, f_curr, f_bc;
    int f_p[4];
    int f_c[4];
    bit f_clr;

    ball_plat_drawer_if bus();

    ball_plat_drawer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_cfg(input int prev, input int curr,
                           input int p0, input int p1, input int p2, input int p3,
                           input int c0, input int c1, input int c2, input int c3,
                           input int bc, input bit clr);
        f_prev = prev; f_curr = curr; f_bc = bc; f_clr = clr;
        f_p[0] = p0; f_p[1] = p1; f_p[2] = p2; f_p[3] = p3;
        f_c[0] = c0; f_c[1] = c1; f_c[2] = c2; f_c[3] = c3;
        bus.prev_ball      = 8'(prev);
        bus.curr_ball      = 8'(curr);
        bus.position_plats = {7'(p3), 7'(p2), 7'(p1), 7'(p0)};
        bus.color_plats    = {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
        bus.color_ball     = 3'(bc);
        bus.clear          = clr;
    endtask

    task automatic push_pix(input int t, input int xx, input int yy, input int cc);
        pix_t e;
        e.cyc = t; e.x = 8'(xx); e.y = 8'(yy); e.c = 3'(cc);
        exp_q.push_back(e);
    endtask

    // Reference model: expected visible pixels and done cycle for a frame started at t0
    task automatic push_frame(input int t0);
        int t;
        t = t0 + 1;
`ifdef DRAWER_CLEAR_EN
        if (f_clr) begin
            for (int yy = 0; yy < 160; yy++) begin
                for (int xx = 0; xx < 160; xx++) begin
                    push_pix(t, xx, yy, 0);
                    t++;
                end
            end
        end
`endif
        for (int dy = 0; dy < 4; dy++) begin
            for (int dx = 0; dx < 4; dx++) begin
                if (f_prev + dy < 160) push_pix(t, 76 + dx, f_prev + dy, 0);
                t++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 8; k++) begin
                push_pix(t, 40 + 20 * i + k, f_p[i], f_c[i]);
                t++;
            end
        end
        for (int dy = 0; dy < 4; dy++) begin
            for (int dx = 0; dx < 4; dx++) begin
                if (f_curr + dy < 160) push_pix(t, 76 + dx, f_curr + dy, f_bc);
                t++;
            end
        end
        done_q.push_back(t);
    endtask

    task automatic start_frame(output int t0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        t0 = cyc;
    endtask

    task automatic drain(input int n, input string tag);
        repeat (n) tick();
        check({tag, "_pixels_left"}, exp_q.size(), 0);
        check({tag, "_dones_left"}, done_q.size(), 0);
    endtask

    initial begin
        int t0;
        int t1;
        pix_t e;

        reset     = 1'b1;
        bus.start = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);

        // Monitor: compares DUT output events against the scoreboard queues
        fork
            forever begin
                @(negedge clk);
                if (!reset) begin
                    if (bus.plot === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL plot_unexpected: got x=%0d y=%0d c=%0d at cycle %0d, required no plot",
                                     bus.x, bus.y, bus.colour, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            check("pix_cycle", cyc, e.cyc);
                            check("pix_x", bus.x, e.x);
                            check("pix_y", bus.y, e.y);
                            check("pix_colour", bus.colour, e.c);
                        end
                    end
                    if (bus.done === 1'b1) begin
                        if (done_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL done_unexpected: got done at cycle %0d, required none", cyc);
                        end else begin
                            check("done_cycle", cyc, done_q.pop_front());
                            check("busy_at_done", bus.busy, 1);
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) tick();
        check("rst_x", bus.x, 0);
        check("rst_y", bus.y, 0);
        check("rst_colour", bus.colour, 0);
        check("rst_plot", bus.plot, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        reset = 1'b0;
        tick();

        // Basic frame
        set_cfg(10, 11, 20, 40, 60, 80, 1, 2, 3, 4, 5, 1'b0);
        start_frame(t0);
        push_frame(t0);
        tick();
        check("busy_cycle1", bus.busy, 1);
        drain(70, "basic");
        check("busy_idle", bus.busy, 0);

        // Ball partly below the screen: rows 160,161 clipped
        set_cfg(10, 158, 20, 40, 60, 80, 1, 2, 3, 4, 5, 1'b0);
        start_frame(t0);
        push_frame(t0);
        drain(70, "clip158");

        // Erase rows wrap past 255 (clipped), ball row 160 clipped, platform y extremes
        set_cfg(254, 157, 127, 0, 100, 159 - 32, 7, 6, 0, 3, 6, 1'b0);
        start_frame(t0);
        push_frame(t0);
        drain(70, "wrap");

        // prev == curr
        set_cfg(50, 50, 1, 2, 3, 4, 2, 4, 6, 1, 3, 1'b0);
        start_frame(t0);
        push_frame(t0);
        drain(70, "same");

        // start re-pulsed at cycles 5 and 65 ignored; new start at 66
        set_cfg(10, 11, 20, 40, 60, 80, 1, 2, 3, 4, 5, 1'b0);
        start_frame(t0);
        push_frame(t0);
        while (cyc < t0 + 4) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        while (cyc < t0 + 64) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        set_cfg(100, 20, 9, 19, 29, 39, 5, 4, 3, 2, 1, 1'b0);
        start_frame(t1);
        push_frame(t1);
        drain(70, "repulse");

        // Inputs change after the latching cycle
        set_cfg(30, 31, 5, 100, 127, 0, 7, 6, 5, 4, 2, 1'b0);
        start_frame(t0);
        push_frame(t0);
        tick();
        bus.prev_ball      = 8'd90;
        bus.curr_ball      = 8'd91;
        bus.position_plats = 28'h5A5A5A5;
        bus.color_plats    = 12'h123;
        bus.color_ball     = 3'd7;
        drain(70, "snapshot");

        // Async reset mid-frame
        set_cfg(10, 11, 20, 40, 60, 80, 1, 2, 3, 4, 5, 1'b0);
        start_frame(t0);
        push_frame(t0);
        while (cyc < t0 + 30) tick();
        reset = 1'b1;
        #1;
        check("midrst_plot", bus.plot, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_x", bus.x, 0);
        check("midrst_y", bus.y, 0);
        check("midrst_colour", bus.colour, 0);
        exp_q.delete();
        done_q.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        drain(70, "after_rst_quiet");
        set_cfg(60, 62, 21, 41, 61, 81, 3, 1, 2, 7, 4, 1'b0);
        start_frame(t0);
        push_frame(t0);
        drain(70, "after_rst");

        // clear request: full-screen clear only when the feature is built in
        set_cfg(10, 11, 20, 40, 60, 80, 1, 2, 3, 4, 5, 1'b1);
        start_frame(t0);
        bus.clear = 1'b0;
        push_frame(t0);
`ifdef DRAWER_CLEAR_EN
        drain(25700, "clear");
`else
        drain(70, "clear_ignored");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ball_plat_drawer.md
Name: ball_plat_drawer

Overview:
Pixel-writer that consumes the game state produced each update tick (previous and current ball position, ball and platform colours, platform positions) and turns it into a serial stream of plot commands for the 160-wide VGA adapter. It runs once per frame: the controller pulses start after the updater has settled. The drawer erases the old ball, redraws the four platforms, draws the new ball, then pulses done back to the controller.

Parameters:
BALL_X, 8'd76, fixed screen column of the ball's left edge
BALL_SIZE, 4, ball edge length in pixels (square)
PLAT_X0, 8'd40, left x of platform 0
PLAT_PITCH, 8'd20, x spacing between platforms
PLAT_W, 8, platform width in pixels (1 row high)
SCREEN_H, 160, rows; pixels with y >= SCREEN_H are clipped

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to draw a frame (from controller)
prev_ball  in  8  ball y to erase
curr_ball  in  8  ball y to draw
position_plats  in  28  platform i y = [7i+6:7i], i=0..3
color_plats  in  12  platform i colour = [3i+2:3i]
color_ball  in  3  ball colour
clear  in  1  full-screen clear request (used only with DRAWER_CLEAR_EN)
x  out  8  pixel x
y  out  8  pixel y
colour  out  3  pixel colour
plot  out  1  write-enable to VGA adapter
busy  out  1  frame in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, any time including mid-frame): state IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0; all counters 0.
- States: IDLE -> [CLEAR] -> ERASE -> PLATS -> BALL -> DONE -> IDLE.
- IDLE: start=1 latches all data inputs into internal registers (cycle 0) and moves to ERASE. Input changes after cycle 0 have no effect on the frame. start while not IDLE is ignored (no queueing).
- One pixel per cycle, registered outputs. The first plot is at cycle 1 and plots are contiguous through the last pixel. done=1 for exactly one cycle, the cycle after the last plot. busy=1 from cycle 1 through the done cycle inclusive.
- ERASE: BALL_SIZE^2 pixels, colour 3'b000, at (BALL_X+dx, prev_ball+dy). Raster order: dy outer, dx inner, both 0..BALL_SIZE-1.
- PLATS: i=0..3, k=0..PLAT_W-1 (i outer). Pixel (PLAT_X0+i*PLAT_PITCH+k, {1'b0,pos_i}), colour color_plats[3i+2:3i].
- BALL: same raster as ERASE at curr_ball, colour color_ball. It is drawn last so it overwrites overlapping platform pixels.
- Clipping: if computed y >= SCREEN_H (8-bit add, also when it carries past 255), plot=0 for that cycle. The cycle is still consumed and x/y still update, so latency is fixed.
- Default latency: 16+32+16 = 64 plots; done at cycle 65.
- prev_ball == curr_ball is legal: erase then redraw, same count.
- x/y/colour hold their last values in IDLE and DONE; plot=0 outside drawing states.

Optional Feature:
DRAWER_CLEAR_EN:
- Defined: if clear=1 at the latching start, a CLEAR state precedes ERASE. It plots colour 0 over all 160 x SCREEN_H pixels (y outer, x inner), 25600 cycles by default, then continues as normal. done is shifted later by the same amount. Intended for game-over/restart.
- Undefined: the clear input is ignored, there is no CLEAR state, and latency is always the base value.

Decomposition:
- Shared package (game_pkg): colour constants (BLACK=3'b000), the screen width 160, state encoding for the drawer, and platform field offsets (7-bit position, 3-bit colour, 4 platforms).
- One natural sub-module, rect_raster: a counter pair that emits (dx,dy) over a w-by-h rectangle with a last flag. It is instantiated once and reloaded per phase.

Test Plan:
- Reset, then start with prev=10, curr=11, plats y={20,40,60,80}, colours={1,2,3,4}, ball=5 -> 64 plots in cycles 1..64: first (76,10,0), 17th (40,20,1), 49th (76,11,5); done at cycle 65 only.
- curr_ball=158 -> ball rows 160,161 suppressed (plot=0 for last 8 BALL cycles), done still at cycle 65.
- start re-pulsed at cycles 5 and 65 -> ignored; exactly one done; a new start at cycle 66 begins a new frame at cycle 67.
- Assert reset at cycle 30 -> all outputs 0 immediately (async); no done; next start runs a full frame.
- Change inputs at cycle 2 -> plotted values still match the cycle-0 snapshot.
- With DRAWER_CLEAR_EN and clear=1 -> 25600 black plots, then 64 frame plots, done at cycle 25665; without the macro -> done at 65.
